// File: rtl/multicycle_control_unit_if.sv
// Control/status bundle between the multi-cycle controller and the RV32I datapath.
// master = controller side, slave = datapath side.
interface multicycle_control_unit_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instruction31_0;
    logic             zero;
    logic             eof;
    logic             next_instruct;
    logic             IorD;
    logic             mem_read;
    logic             mem_write;
    logic             IRwrite;
    logic             MemtoReg;
    logic             reg_write;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic             PCSource;
    logic [5:0]       alu_cnt;
    logic [5:0]       no_instruct;
    logic [3:0]       state;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  instruction31_0, zero, eof,
        output next_instruct, IorD, mem_read, mem_write, IRwrite,
        output MemtoReg, reg_write, ALUSrcA, ALUSrcB, PCSource,
        output alu_cnt, no_instruct, state, halted, illegal, retired
    );

    modport slave (
        output instruction31_0, zero, eof,
        input  next_instruct, IorD, mem_read, mem_write, IRwrite,
        input  MemtoReg, reg_write, ALUSrcA, ALUSrcB, PCSource,
        input  alu_cnt, no_instruct, state, halted, illegal, retired
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Sequencing FSM for the unpipelined multi-cycle RV32I datapath.
// State is registered; controls decode from state (Mealy on zero/eof).
module multicycle_control_unit #(
    parameter logic [5:0] NO_INSTRUCT = 6'd16,
    parameter int         CNT_W       = 32
) (
    input logic                          clk,
    input logic                          rst,
    multicycle_control_unit_if.master    bus
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        EXEC_I    = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        PC_INC    = 4'd10,
        HALT      = 4'd11
    } state_t;

    localparam logic [5:0] ALU_ADD  = 6'd0;
    localparam logic [5:0] ALU_SUB  = 6'd1;
    localparam logic [5:0] ALU_AND  = 6'd2;
    localparam logic [5:0] ALU_OR   = 6'd3;
    localparam logic [5:0] ALU_XOR  = 6'd4;
    localparam logic [5:0] ALU_SLL  = 6'd5;
    localparam logic [5:0] ALU_SRL  = 6'd6;
    localparam logic [5:0] ALU_SRA  = 6'd7;
    localparam logic [5:0] ALU_SLT  = 6'd8;
    localparam logic [5:0] ALU_SLTU = 6'd9;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    logic             ni_c, iord_c, mr_c, mw_c, irw_c;
    logic             m2r_c, rw_c, asa_c, pcs_c;
    logic [1:0]       asb_c;
    logic [5:0]       alu_c;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_r, is_i, is_ld, is_st, is_br;
    logic       r_f7_ok, taken;
    logic       unused_ir;

    assign opcode    = bus.instruction31_0[6:0];
    assign f3        = bus.instruction31_0[14:12];
    assign f7        = bus.instruction31_0[31:25];
    assign unused_ir = ^{bus.instruction31_0[24:15],
                         bus.instruction31_0[11:7]};

    assign is_r  = opcode == 7'b0110011;
    assign is_i  = opcode == 7'b0010011;
    assign is_ld = (opcode == 7'b0000011) && (f3 == 3'b010);
    assign is_st = (opcode == 7'b0100011) && (f3 == 3'b010);
    assign is_br = (opcode == 7'b1100011) &&
                   ((f3 == 3'b000) || (f3 == 3'b001));

    // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding.
    assign r_f7_ok = (f7 == 7'b0000000) ||
                     ((f7 == 7'b0100000) &&
                      ((f3 == 3'b000) || (f3 == 3'b101)));

    assign taken = ((f3 == 3'b000) && bus.zero) ||
                   ((f3 == 3'b001) && !bus.zero);

    function automatic logic [5:0] alu_map(
        input logic [2:0] fn3,
        input logic       alt
    );
        logic [5:0] op;
        unique case (fn3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        ni_c      = 1'b0;
        iord_c    = 1'b0;
        mr_c      = 1'b0;
        mw_c      = 1'b0;
        irw_c     = 1'b0;
        m2r_c     = 1'b0;
        rw_c      = 1'b0;
        asa_c     = 1'b0;
        asb_c     = 2'b00;
        pcs_c     = 1'b0;
        alu_c     = ALU_ADD;
        unique case (state_q)
            FETCH: begin
                if (bus.eof) begin
                    state_d = HALT;
                end else begin
                    mr_c    = 1'b1;
                    irw_c   = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                asb_c = 2'b10;
                unique case (1'b1)
                    is_r:           state_d = EXEC_R;
                    is_i:           state_d = EXEC_I;
                    is_ld || is_st: state_d = MEM_ADDR;
                    is_br:          state_d = BRANCH;
                    default: begin
                        state_d   = HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: begin
                asa_c   = 1'b1;
                asb_c   = 2'b10;
                state_d = is_ld ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                iord_c  = 1'b1;
                mr_c    = 1'b1;
                state_d = MEM_WB;
            end
            MEM_WB: begin
                m2r_c   = 1'b1;
                rw_c    = 1'b1;
                state_d = PC_INC;
            end
            MEM_WRITE: begin
                iord_c  = 1'b1;
                mw_c    = 1'b1;
                state_d = PC_INC;
            end
            EXEC_R: begin
                asa_c = 1'b1;
                alu_c = alu_map(f3, f7[5]);
                if (r_f7_ok) begin
                    state_d = ALU_WB;
                end else begin
                    state_d   = HALT;
                    illegal_d = 1'b1;
                end
            end
            EXEC_I: begin
                asa_c   = 1'b1;
                asb_c   = 2'b10;
                alu_c   = alu_map(f3, (f3 == 3'b101) && f7[5]);
                state_d = ALU_WB;
            end
            ALU_WB: begin
                rw_c    = 1'b1;
                state_d = PC_INC;
            end
            BRANCH: begin
                asa_c = 1'b1;
                alu_c = ALU_SUB;
                if (taken) begin
                    pcs_c   = 1'b1;
                    ni_c    = 1'b1;
                    retire  = 1'b1;
                    state_d = FETCH;
                end else begin
                    state_d = PC_INC;
                end
            end
            PC_INC: begin
                asb_c   = 2'b01;
                ni_c    = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d   = HALT;
                illegal_d = 1'b1;
            end
        endcase
    end

    assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Reset forces every control low even while state is still settling.
    assign bus.next_instruct = rst & ni_c;
    assign bus.IorD          = rst & iord_c;
    assign bus.mem_read      = rst & mr_c;
    assign bus.mem_write     = rst & mw_c;
    assign bus.IRwrite       = rst & irw_c;
    assign bus.MemtoReg      = rst & m2r_c;
    assign bus.reg_write     = rst & rw_c;
    assign bus.ALUSrcA       = rst & asa_c;
    assign bus.ALUSrcB       = rst ? asb_c : 2'b00;
    assign bus.PCSource      = rst & pcs_c;
    assign bus.alu_cnt       = rst ? alu_c : 6'd0;
    assign bus.no_instruct   = NO_INSTRUCT;
    assign bus.state         = state_q;
    assign bus.halted        = rst & (state_q == HALT);
    assign bus.illegal       = illegal_q;
    assign bus.retired       = retired_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore/Mealy FSM that sequences the RV32I multi-cycle unpipelined datapath.
- Consumes `instruction31_0`, `zero` and `eof` from the datapath.
- Drives every datapath control input: `next_instruct`, `IorD`, `mem_write`, `mem_read`, `IRwrite`, `MemtoReg`, `reg_write`, `ALUSrcA`, `PCSource`, `ALUSrcB`, `alu_cnt`, `no_instruct`.
- Also provides halt/illegal status and a retired-instruction counter.

Parameters:
- NO_INSTRUCT, 6'd16, program length in instructions; driven constant on `no_instruct`.
- CNT_W, 32, width of `retired` counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- instruction31_0  in  32  IR contents.
- zero  in  1  ALU zero flag (combinational, current cycle).
- eof  in  1  PC has passed program end.
- next_instruct  out  1  PC load enable.
- IorD  out  1  memory address select: 1=ALUOut, 0=PC.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- IRwrite  out  1  IR load enable.
- MemtoReg  out  1  write-back select: 1=memory data reg, 0=ALUOut.
- reg_write  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 1=reg A, 0=PC.
- ALUSrcB  out  2  ALU B select: 00=reg B, 01=4, 10=immediate.
- PCSource  out  1  new-PC select: 1=ALUOut, 0=ALU result.
- alu_cnt  out  6  ALU operation.
- no_instruct  out  6  = NO_INSTRUCT.
- state  out  4  current state (debug).
- halted  out  1  FSM in HALT.
- illegal  out  1  sticky: halted on unsupported instruction.
- retired  out  CNT_W  instructions completed.

Behaviour:
- Reset: on posedge `clk` with `rst`==0, regardless of current state:
  - state=FETCH; `illegal`=0; `retired`=0.
  - All control outputs 0 during reset cycles.
- Unless listed for a state, every control output is 0.
- `alu_cnt` codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
- States (encoding in brackets):
  - FETCH[0]:
    - If `eof`=1: all outputs 0, next=HALT.
    - Else: IorD=0, mem_read=1, IRwrite=1, next=DECODE.
  - DECODE[1]: ALUSrcA=0, ALUSrcB=10, alu_cnt=ADD, so ALUOut=PC+imm. Next state by opcode:
    - 0110011 -> EXEC_R.
    - 0010011 -> EXEC_I.
    - 0000011 (funct3=010) or 0100011 (funct3=010) -> MEM_ADDR.
    - 1100011 (funct3 000/001) -> BRANCH.
    - Anything else -> HALT with illegal=1.
  - MEM_ADDR[2]: ALUSrcA=1, ALUSrcB=10, ADD. Next: load -> MEM_READ, store -> MEM_WRITE.
  - MEM_READ[3]: IorD=1, mem_read=1. Next MEM_WB.
  - MEM_WB[4]: MemtoReg=1, reg_write=1. Next PC_INC.
  - MEM_WRITE[5]: IorD=1, mem_write=1. Next PC_INC.
  - EXEC_R[6]: ALUSrcA=1, ALUSrcB=00. alu_cnt from funct3/funct7[5]:
    - 000: ADD, or SUB if f7[5]=1.
    - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
    - 101: SRL, or SRA if f7[5]=1.
    - 110: OR. 111: AND.
    - Any other funct7 value -> HALT, illegal=1.
    - Next ALU_WB.
  - EXEC_I[7]: ALUSrcA=1, ALUSrcB=10. Same funct3 map except funct3=000 is always ADD; f7[5] is used only for funct3=101 (SRAI). Next ALU_WB.
  - ALU_WB[8]: MemtoReg=0, reg_write=1. Next PC_INC.
  - BRANCH[9]: ALUSrcA=1, ALUSrcB=00, alu_cnt=SUB. taken = (BEQ & zero) | (BNE & ~zero); Mealy on `zero`.
    - Taken: PCSource=1, next_instruct=1, retired++, next FETCH.
    - Not taken: next PC_INC.
  - PC_INC[10]: ALUSrcA=0, ALUSrcB=01, ADD, PCSource=0, next_instruct=1, retired++. Next FETCH.
  - HALT[11]: all control outputs 0, halted=1. Remains until reset.
- CPI:
  - R/I-type: 5.
  - LW: 6.
  - SW: 5.
  - Branch taken: 3; not taken: 4.
- `retired` wraps modulo 2^CNT_W.
- `illegal` is sticky and is cleared only by reset.
- States 12–15 are unreachable; if entered, next=HALT with illegal=1.

Test Plan:
- Reset check: `rst`=0 for 2 cycles -> all outputs 0, state=0, retired=0. Release -> FETCH cycle shows IorD=0, mem_read=1, IRwrite=1.
- ADD x3,x1,x2 (0x002081B3):
  - States 0,1,6,8,10,0.
  - EXEC_R: alu_cnt=0, ALUSrcA=1, ALUSrcB=00.
  - ALU_WB: reg_write=1.
  - PC_INC: next_instruct=1, ALUSrcB=01.
  - retired 0->1.
- ALU code decode: SUB x4,x1,x2 (0x40208233) gives alu_cnt=1; SRAI x4,x1,3 (0x4030D213) gives alu_cnt=7 with ALUSrcB=10.
- LW x5,8(x1) (0x0080A283):
  - States 0,1,2,3,4,10.
  - MEM_READ: IorD=1, mem_read=1.
  - MEM_WB: MemtoReg=1, reg_write=1.
- SW x5,8(x1) (0x0050A423):
  - States 0,1,2,5,10.
  - mem_write=1 for exactly one cycle; reg_write never 1.
- BEQ x1,x2,+8 (0x00208463):
  - zero=1 in BRANCH -> PCSource=1, next_instruct=1, next state FETCH.
  - zero=0 -> PC_INC follows.
  - BNE (0x00209463) gives the inverse outcomes.
- Halt conditions:
  - Opcode 0x0000007F -> DECODE->HALT, illegal=1, halted=1, outputs 0 for 10 cycles; reset recovers.
  - eof=1 in FETCH -> HALT with mem_read=0.
